// File: rtl/ttc_intr_sched14.sv
// rtl/ttc_intr_sched14.sv - round-robin interrupt scheduler for timer/counter channels
// Optional ack timeout enabled by defining TTC_SCHED_TIMEOUT_EN.
module ttc_intr_sched14 #(
  parameter int NUM_CH    = 3,
  parameter int ID_W      = 2,
  parameter int TO_CYCLES = 15,
  parameter int TO_W      = 4
) (
  input  logic              pclk14,
  input  logic              n_p_reset14,
  input  logic [NUM_CH-1:0] ch_intr,
  input  logic              sched_en,
  input  logic              irq_ack,
  output logic              irq_out,
  output logic [ID_W-1:0]   irq_id,
  output logic [NUM_CH-1:0] clear_out,
  output logic              busy,
  output logic              timeout_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PEND  = 2'd1;
  localparam logic [1:0] CLEAR = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  if (NUM_CH < 2 || NUM_CH > 4 || (2 ** ID_W) < NUM_CH || (2 ** TO_W) <= TO_CYCLES) begin : g_bad_params
    $error("ttc_intr_sched14: illegal parameter combination");
  end

  logic [1:0]      state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] cand;
  logic            found;

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = ID_W'((int'(rr_ptr) + i) % NUM_CH);
      if (!found && ch_intr[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

`ifdef TTC_SCHED_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            to_err;
  assign timeout_err = to_err;
`else
  assign timeout_err = 1'b0;
`endif

  // irq_id doubles as the grant register for the whole service sequence.
  always_ff @(posedge pclk14 or negedge n_p_reset14) begin
    if (!n_p_reset14) begin
      state     <= IDLE;
      irq_out   <= 1'b0;
      irq_id    <= '0;
      clear_out <= '0;
      busy      <= 1'b0;
      rr_ptr    <= ID_W'(NUM_CH - 1);
`ifdef TTC_SCHED_TIMEOUT_EN
      to_cnt    <= '0;
      to_err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (sched_en && found) begin
            state   <= PEND;
            busy    <= 1'b1;
            irq_out <= 1'b1;
            irq_id  <= winner;
            rr_ptr  <= winner;
`ifdef TTC_SCHED_TIMEOUT_EN
            to_cnt  <= '0;
`endif
          end
        end
        PEND: begin
          if (irq_ack) begin
            irq_out   <= 1'b0;
            clear_out <= NUM_CH'(1) << irq_id;
            state     <= CLEAR;
          end else if (!ch_intr[irq_id]) begin
            irq_out <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
`ifdef TTC_SCHED_TIMEOUT_EN
          end else if (to_cnt == TO_W'(TO_CYCLES - 1)) begin
            irq_out <= 1'b0;
            busy    <= 1'b0;
            to_err  <= 1'b1;
            state   <= IDLE;
          end else begin
            to_cnt  <= to_cnt + 1'b1;
`endif
          end
        end
        CLEAR: begin
          clear_out <= '0;
          state     <= DRAIN;
        end
        DRAIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          irq_out   <= 1'b0;
          clear_out <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
